// File: rtl/sram_4096x16_sp.sv
// Single-port synchronous SRAM with a registered read port and a gated, never-tristated output.
// Optional macro SRAM_WRITE_THROUGH_EN: write cycles also load the written word into the output register.
module sram_4096x16_sp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              OE,
  input  logic              CS
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_dout;
  logic              w_in_range;
  logic              w_wr_en;
  logic              w_rd_en;

  // One extra bit so the comparison also holds when DEPTH == 2**ADDR_W.
  assign w_in_range = ({1'b0, A} < (ADDR_W + 1)'(DEPTH));
  assign w_wr_en    = !RST && CS && !WEB;
  assign w_rd_en    = !RST && CS &&  WEB;

  // NOTE: the array has no reset branch on purpose; clearing it would need a
  // port per word, which prevents mapping onto a RAM macro.
  always_ff @(posedge CK) begin
    if (w_wr_en && w_in_range) begin
      r_mem[A] <= DI;
    end
  end

  // NOTE: non-blocking assignments here, so a read in the same edge as a write
  // elsewhere always sees the array's pre-edge contents.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_dout <= '0;
    end else if (w_rd_en) begin
      r_dout <= w_in_range ? r_mem[A] : '0;
    end else if (w_wr_en) begin
`ifdef SRAM_WRITE_THROUGH_EN
      r_dout <= DI;
`else
      r_dout <= r_dout;
`endif
    end
  end

  assign DO = OE ? r_dout : '0;

endmodule

// File: tb/tb_sram_4096x16_sp.sv
// Self-checking bench for sram_4096x16_sp: directed test-plan scenarios followed by
// randomized traffic, all scored against a word-array reference model.
module tb_sram_4096x16_sp;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  logic              CK = 1'b0;
  logic              RST;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              WEB;
  logic              OE;
  logic              CS;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_dout;

  sram_4096x16_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CK (CK),
    .RST(RST),
    .A  (A),
    .DI (DI),
    .DO (DO),
    .WEB(WEB),
    .OE (OE),
    .CS (CS)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: DO=0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one rising edge, taken straight from the access rules.
  task automatic model_edge();
    if (RST) begin
      m_dout = '0;
    end else if (CS) begin
      if (!WEB) begin
        if (int'(A) < DEPTH) m_mem[A] = DI;
`ifdef SRAM_WRITE_THROUGH_EN
        m_dout = DI;
`endif
      end else begin
        m_dout = (int'(A) < DEPTH) ? m_mem[A] : '0;
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] model_do();
    return OE ? m_dout : '0;
  endfunction

  // Drive one cycle of inputs, clock it, and compare DO against the model.
  task automatic step(input string tag, input logic rst_i, input logic cs_i, input logic web_i,
                      input logic oe_i, input logic [ADDR_W-1:0] a_i, input logic [DATA_W-1:0] di_i);
    RST = rst_i; CS = cs_i; WEB = web_i; OE = oe_i; A = a_i; DI = di_i;
    @(posedge CK);
    model_edge();
    #1;
    check(tag, DO, model_do());
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    m_dout = '0;

    // Reset
    step("reset", 1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
    check("reset_zero", DO, 16'h0000);

    // Sequential fill, then back-to-back read-back
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b0, 1'b1, 1'b0, 1'b1, ADDR_W'(i), DATA_W'(i) ^ 16'hA5A5);
    for (int i = 0; i < DEPTH; i++) begin
      step("rd_seq_model", 1'b0, 1'b1, 1'b1, 1'b1, ADDR_W'(i), '0);
      check("rd_seq", DO, DATA_W'(i) ^ 16'hA5A5);
    end

    // Write then immediate read of the same address
    step("raw_wr", 1'b0, 1'b1, 1'b0, 1'b1, 12'h7FF, 16'h1234);
    step("raw_rd_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h7FF, '0);
    check("raw_rd", DO, 16'h1234);

    // Write-through option
    step("wt_model", 1'b0, 1'b1, 1'b0, 1'b1, 12'h010, 16'hBEEF);
`ifdef SRAM_WRITE_THROUGH_EN
    check("write_through", DO, 16'hBEEF);
`else
    check("write_hold", DO, 16'h1234);
`endif
    step("wt_rdback_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h010, '0);
    check("wt_rdback", DO, 16'hBEEF);

    // Deselected write must not land
    step("cs0_wr_model", 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 16'hFFFF);
    check("cs0_hold", DO, 16'hBEEF);
    step("cs0_rd_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, '0);
    check("cs0_rd", DO, 16'hA5A5);

    // Output enable is combinational and does not disturb the output register
    step("oe0_model", 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, '0);
    check("oe0", DO, 16'h0000);
    OE = 1'b1;
    #1;
    check("oe1_no_edge", DO, 16'hA5A5);

    // Reset in the middle of a write stream
    step("rstw_wr5", 1'b0, 1'b1, 1'b0, 1'b1, 12'h005, 16'h0001);
    step("rstw_rst_model", 1'b1, 1'b1, 1'b0, 1'b1, 12'h006, 16'h0002);
    check("rstw_rst", DO, 16'h0000);
    step("rstw_rd5_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h005, '0);
    check("rstw_rd5", DO, 16'h0001);
    step("rstw_rd6_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h006, '0);
    check("rstw_rd6", DO, 16'h0006 ^ 16'hA5A5);

    // Randomized traffic; every word is known after the fill
    for (int n = 0; n < 3000; n++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0),
           ADDR_W'($urandom),
           DATA_W'($urandom));
    end

    // Final read of a randomly chosen address with OE held high
    held = m_mem[12'h123];
    step("final_rd_model", 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, '0);
    check("final_rd", DO, held);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
